// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the I-cache read handshake and
// feeds decode through a valid/ready IF/ID register with a one-entry hold buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic [31:0] redirect_tgt;
  logic        out_free;
  logic        transfer;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign transfer     = id_valid_q && id_ready;
  assign out_free     = !id_valid_q || id_ready;

  // A request stays up in DROP so the outstanding miss can complete and be discarded.
  assign imem_read    = !rst && (state_q == ST_REQ || state_q == ST_DROP);
  assign imem_address = addr_q;

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;

  // NOTE: every variable written here gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tgt_d        = tgt_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;

    if (transfer) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end

    case (state_q)
      ST_REQ: begin
        if (imem_resp) begin
          if (redirect_valid) begin
            addr_d = redirect_tgt;
          end else if (out_free) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = addr_q;
            addr_d     = addr_q + 32'd4;
          end else begin
            hold_valid_d = 1'b1;
            hold_instr_d = imem_rdata;
            hold_pc_d    = addr_q;
            addr_d       = addr_q + 32'd4;
            state_d      = ST_HOLD;
          end
        end else if (redirect_valid) begin
          tgt_d   = redirect_tgt;
          state_d = ST_DROP;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          hold_valid_d = 1'b0;
          addr_d       = redirect_tgt;
          state_d      = ST_REQ;
        end else if (id_ready) begin
          hold_valid_d = 1'b0;
          id_valid_d   = 1'b1;
          id_instr_d   = hold_instr_q;
          id_pc_d      = hold_pc_q;
          state_d      = ST_REQ;
        end
      end

      ST_DROP: begin
        if (redirect_valid) begin
          tgt_d = redirect_tgt;
        end
        // The wrong-path response retires the old request; only then may the address move.
        if (imem_resp) begin
          addr_d  = redirect_valid ? redirect_tgt : tgt_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (redirect_valid) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      addr_q       <= RESET_PC;
      tgt_q        <= 32'd0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'd0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tgt_q        <= tgt_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each vector drives one cycle of inputs and checks the
// outputs seen in that cycle, before the clock edge that consumes the inputs.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        resp;
    logic [31:0] rdata;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    imem_resp      = v.resp;
    imem_rdata     = v.rdata;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    id_ready       = v.rdy;
    #1;
    check({tag, " imem_read"},    {31'd0, imem_read}, {31'd0, v.e_read});
    check({tag, " imem_address"}, imem_address,       v.e_addr);
    check({tag, " id_valid"},     {31'd0, id_valid},  {31'd0, v.e_valid});
    check({tag, " id_instr"},     id_instr,           v.e_instr);
    check({tag, " id_pc"},        id_pc,              v.e_pc);
  endtask

  initial begin
    //              rst   resp  rdata          rv    rpc            rdy   read  addr           valid instr          pc
    // reset, then hit stream
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h4000_0000, 1'b0, NOP,           32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0000, 1'b0, NOP,           32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h1111_0000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0000, 1'b0, NOP,           32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h1111_0004, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0004, 1'b1, 32'h1111_0000, 32'h4000_0000});
    // stall: resp for 0x08 arrives while decode is not ready -> HOLD
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h4000_0008, 1'b1, 32'h1111_0004, 32'h4000_0004});
    vecs.push_back('{1'b0, 1'b1, 32'h1111_0008, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4000_0008, 1'b1, 32'h1111_0004, 32'h4000_0004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h4000_000C, 1'b1, 32'h1111_0004, 32'h4000_0004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h4000_000C, 1'b1, 32'h1111_0004, 32'h4000_0004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h4000_000C, 1'b1, 32'h1111_0004, 32'h4000_0004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_000C, 1'b1, 32'h1111_0008, 32'h4000_0008});
    vecs.push_back('{1'b0, 1'b1, 32'h1111_000C, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_000C, 1'b0, NOP,           32'h4000_0008});
    // redirect while the read of 0x10 is outstanding; resp 5 cycles later is dropped
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0100, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 32'h1111_000C, 32'h4000_000C});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0010, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0010, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0010, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0010, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b1, BAD,           1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0010, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0100, 1'b0, NOP,           32'h4000_000C});
    // double redirect in DROP (0x100 then 0x202 with low bits ignored) -> restart at 0x200
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h4000_0100, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0202, 1'b1, 1'b1, 32'h4000_0100, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b1, BAD,           1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0100, 1'b0, NOP,           32'h4000_000C});
    vecs.push_back('{1'b0, 1'b1, 32'h2222_0200, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 1'b0, NOP,           32'h4000_000C});
    // redirect coincident with resp while decode stalled: no HOLD entry
    vecs.push_back('{1'b0, 1'b1, BAD,           1'b1, 32'h4000_0400, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 32'h2222_0200, 32'h0000_0200});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h4000_0400, 1'b0, NOP,           32'h0000_0200});
    // wrap: redirect to 0xFFFFFFFF (-> 0xFFFFFFFC), next address wraps to 0
    vecs.push_back('{1'b0, 1'b1, BAD,           1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h4000_0400, 1'b0, NOP,           32'h0000_0200});
    vecs.push_back('{1'b0, 1'b1, 32'h3333_FFFC, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, NOP,           32'h0000_0200});
    // enter DROP, then reset with a late resp that must be ignored
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0800, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h3333_FFFC, 32'hFFFF_FFFC});
    vecs.push_back('{1'b1, 1'b1, BAD,           1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, NOP,           32'hFFFF_FFFC});
    vecs.push_back('{1'b1, 1'b1, BAD,           1'b0, 32'h0,         1'b1, 1'b0, 32'h4000_0000, 1'b0, NOP,           32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0000, 1'b0, NOP,           32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4444_0000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0000, 1'b0, NOP,           32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h4000_0004, 1'b1, 32'h4444_0000, 32'h4000_0000});

    rst            = 1'b1;
    imem_resp      = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Redirect while in HOLD: the held word must never reach decode.
    apply("hold_enter",  '{1'b0, 1'b1, 32'h5555_0004, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4000_0004, 1'b1, 32'h4444_0000, 32'h4000_0000});
    apply("hold_redir",  '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_1000, 1'b0, 1'b0, 32'h4000_0008, 1'b1, 32'h4444_0000, 32'h4000_0000});
    apply("hold_after",  '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_1000, 1'b0, NOP,           32'h4000_0000});
    apply("hold_fetch",  '{1'b0, 1'b1, 32'h6666_1000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_1000, 1'b0, NOP,           32'h4000_0000});
    // DROP completing with a fresh redirect in the same cycle: the newest target wins.
    apply("drop_enter",  '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_2000, 1'b1, 1'b1, 32'h4000_1004, 1'b1, 32'h6666_1000, 32'h4000_1000});
    apply("drop_resp",   '{1'b0, 1'b1, BAD,           1'b1, 32'h4000_3000, 1'b1, 1'b1, 32'h4000_1004, 1'b0, NOP,           32'h4000_1000});
    apply("drop_after",  '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_3000, 1'b0, NOP,           32'h4000_1000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
